my_dmux4way16_buf: RTL and testbench

MY_DMUX4WAY16_BUF -- requirements
Module: my_dmux4way16_buf

---
 rtl/my_dmux4way16_buf_pkg.sv | 26 ++
 rtl/my_dmux4way16_buf_lane.sv | 29 ++
 rtl/my_dmux4way16_buf.sv | 60 ++++++
 tb/tb_my_dmux4way16_buf.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/my_dmux4way16_buf_pkg.sv
// Shared widths, lane indices and the dmux/mux gate helpers used for routing.
package my_dmux4way16_buf_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0] LANE_A = SEL_W'(0);
  localparam logic [SEL_W-1:0] LANE_B = SEL_W'(1);
  localparam logic [SEL_W-1:0] LANE_C = SEL_W'(2);
  localparam logic [SEL_W-1:0] LANE_D = SEL_W'(3);

  // 1-to-4 demultiplexer of a single enable bit.
  function automatic logic [LANES_DEF-1:0] dmux4(input logic en, input logic [SEL_W-1:0] s);
    logic [LANES_DEF-1:0] y;
    y = '0;
    y[s] = en;
    return y;
  endfunction

  // 4-to-1 multiplexer of a single bit.
  function automatic logic mux4(input logic [LANES_DEF-1:0] v, input logic [SEL_W-1:0] s);
    return v[s];
  endfunction

endpackage

// File: rtl/my_dmux4way16_buf_lane.sv
// One output lane: data register plus full flag with load, ack and sync reset.
module my_lane_reg16
  import my_dmux4way16_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // Load wins over ack so a same-cycle refill keeps the lane full.
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/my_dmux4way16_buf.sv
// Buffered 1-to-4 demultiplexer with direct or round-robin lane targeting.
module my_dmux4way16_buf
  import my_dmux4way16_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  input  logic             rr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ack
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] target;
  logic             accept;
  logic [LANES-1:0] load_vec;
  logic [WIDTH-1:0] lane_q [LANES];

  assign target   = rr ? ptr : sel;
  assign in_ready = !reset && (!mux4(out_valid, target) || mux4(out_ack, target));
  assign accept   = in_valid && in_ready;
  assign load_vec = dmux4(accept, target);

  // Pointer only moves on a word actually taken in round-robin mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= LANE_A;
    end else if (accept && rr) begin
      ptr <= ptr + SEL_W'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    my_lane_reg16 #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (load_vec[i]),
      .ack   (out_ack[i]),
      .d     (in),
      .q     (lane_q[i]),
      .valid (out_valid[i])
    );
  end

  assign a = lane_q[LANE_A];
  assign b = lane_q[LANE_B];
  assign c = lane_q[LANE_C];
  assign d = lane_q[LANE_D];

endmodule

// File: tb/tb_my_dmux4way16_buf.sv
// Randomized and directed checks of my_dmux4way16_buf against a lane-array model.
module tb_my_dmux4way16_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = '0;
  logic [1:0]  sel = '0;
  logic        rr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a, b, c, d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack = '0;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [15:0] mdata [4];
  bit          mvalid [4];
  int          mptr;
  logic        rdy_obs, rdy_exp;

  always #5 clk = ~clk;

  my_dmux4way16_buf dut (
    .clk(clk), .reset(reset), .in(in), .sel(sel), .rr(rr),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ack(out_ack)
  );

  function automatic logic [67:0] exp_state();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mvalid[i];
    return {mdata[3], mdata[2], mdata[1], mdata[0], v};
  endfunction

  function automatic logic [67:0] obs_state();
    return {d, c, b, a, out_valid};
  endfunction

  // Drive one cycle, record pre-edge ready, advance the model with the spec rules.
  task automatic step(input logic rst, input logic iv, input logic [15:0] din,
                      input logic [1:0] s, input logic r, input logic [3:0] ack);
    int tgt;
    reset = rst; in_valid = iv; in = din; sel = s; rr = r; out_ack = ack;
    #1;
    tgt = r ? mptr : int'(s);
    rdy_exp = !rst && (!mvalid[tgt] || ack[tgt]);
    rdy_obs = in_ready;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin mdata[i] = '0; mvalid[i] = 0; end
      mptr = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (ack[i] && mvalid[i]) mvalid[i] = 0;
      if (iv && rdy_exp) begin
        mdata[tgt] = din;
        mvalid[tgt] = 1;
        if (r) mptr = (mptr + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 4'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 16'hDEAD, 2'd0, 1'b0, 4'b1111);
    tests++;
    if (rdy_obs !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", rdy_obs); end
    tests++;
    if (obs_state() !== 68'h0) begin fails++; $display("FAIL reset_state: got %h expected 0", obs_state()); end
  endtask

  task automatic test_direct_fill();
    logic [15:0] w [4];
    w[0] = 16'h5555; w[1] = 16'hAAAA; w[2] = 16'h00FF; w[3] = 16'hFF00;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, w[i], 2'(i), 1'b0, 4'b0);
      tests++;
      if (obs_state() !== exp_state()) begin
        fails++; $display("FAIL direct_fill_%0d: got %h expected %h", i, obs_state(), exp_state());
      end
    end
    tests++;
    if ({d, c, b, a, out_valid} !== {16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555, 4'b1111}) begin
      fails++; $display("FAIL direct_fill_final: got %h", {d, c, b, a, out_valid});
    end
  endtask

  task automatic test_backpressure();
    step(1'b0, 1'b1, 16'hBEEF, 2'd0, 1'b0, 4'b0);
    tests++;
    if (rdy_obs !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b expected 0", rdy_obs); end
    tests++;
    if (a !== 16'h5555 || out_valid[0] !== 1'b1) begin
      fails++; $display("FAIL bp_hold: got a=%h v=%b expected a=5555 v=1", a, out_valid[0]);
    end
    step(1'b0, 1'b1, 16'h1234, 2'd0, 1'b0, 4'b0001);
    tests++;
    if (rdy_obs !== 1'b1) begin fails++; $display("FAIL bp_ack_ready: got %b expected 1", rdy_obs); end
    tests++;
    if (a !== 16'h1234 || out_valid[0] !== 1'b1) begin
      fails++; $display("FAIL bp_reload: got a=%h v=%b expected a=1234 v=1", a, out_valid[0]);
    end
  endtask

  task automatic test_ack_only();
    logic [15:0] a0, b0, c0, d0;
    a0 = a; b0 = b; c0 = c; d0 = d;
    step(1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 4'b1010);
    tests++;
    if (out_valid !== 4'b0101 || {a, b, c, d} !== {a0, b0, c0, d0}) begin
      fails++; $display("FAIL ack_only: got v=%b data=%h expected v=0101 data=%h",
                        out_valid, {a, b, c, d}, {a0, b0, c0, d0});
    end
    // ack of an already empty lane is ignored
    step(1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 4'b1010);
    tests++;
    if (out_valid !== 4'b0101) begin fails++; $display("FAIL ack_empty: got %b expected 0101", out_valid); end
  endtask

  task automatic test_round_robin();
    step(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 4'b0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 16'(i), 2'd3, 1'b1, 4'b0);
    step(1'b0, 1'b1, 16'd5, 2'd3, 1'b1, 4'b0001);
    tests++;
    if ({a, b, c, d} !== {16'd5, 16'd2, 16'd3, 16'd4} || out_valid !== 4'b1111) begin
      fails++; $display("FAIL rr_fill: got %h v=%b expected 0005000200030004 v=1111", {a, b, c, d}, out_valid);
    end
    // ptr now 1: lane b full -> stall, then ack b lets the next word into b
    step(1'b0, 1'b1, 16'd6, 2'd0, 1'b1, 4'b0);
    tests++;
    if (rdy_obs !== 1'b0 || b !== 16'd2) begin
      fails++; $display("FAIL rr_stall: got rdy=%b b=%h expected rdy=0 b=0002", rdy_obs, b);
    end
    step(1'b0, 1'b1, 16'd6, 2'd0, 1'b1, 4'b0010);
    tests++;
    if (b !== 16'd6 || obs_state() !== exp_state()) begin
      fails++; $display("FAIL rr_ptr1: got %h expected %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 4'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hA0 + 16'(i), 2'(i), 1'b0, 4'b0);
    step(1'b0, 1'b1, 16'hB0, 2'd0, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 16'hB1, 2'd0, 1'b1, 4'b0010);
    step(1'b1, 1'b1, 16'hCC, 2'd2, 1'b1, 4'b0100);
    tests++;
    if (rdy_obs !== 1'b0) begin fails++; $display("FAIL mid_reset_ready: got %b expected 0", rdy_obs); end
    tests++;
    if (obs_state() !== 68'h0) begin fails++; $display("FAIL mid_reset_state: got %h expected 0", obs_state()); end
    step(1'b0, 1'b1, 16'h77, 2'd3, 1'b1, 4'b0);
    tests++;
    if (a !== 16'h77 || out_valid !== 4'b0001) begin
      fails++; $display("FAIL mid_reset_ptr0: got a=%h v=%b expected a=0077 v=0001", a, out_valid);
    end
  endtask

  task automatic test_mode_switch();
    step(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 4'b0);
    step(1'b0, 1'b1, 16'h11, 2'd0, 1'b1, 4'b0);
    step(1'b0, 1'b1, 16'h22, 2'd0, 1'b1, 4'b0);
    step(1'b0, 1'b1, 16'h33, 2'd0, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 16'h44, 2'd0, 1'b1, 4'b0);
    tests++;
    if ({a, b, c, d} !== {16'h33, 16'h22, 16'h44, 16'h0} || out_valid !== 4'b0111) begin
      fails++; $display("FAIL mode_switch: got %h v=%b expected 0033002200440000 v=0111", {a, b, c, d}, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) == 0), 1'($urandom), 16'($urandom), 2'($urandom),
           1'($urandom), 4'($urandom));
      tests++;
      if (rdy_obs !== rdy_exp) begin
        fails++; $display("FAIL rand_ready_%0d: got %b expected %b", n, rdy_obs, rdy_exp);
      end
      tests++;
      if (obs_state() !== exp_state()) begin
        fails++; $display("FAIL rand_state_%0d: got %h expected %h", n, obs_state(), exp_state());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mdata[i] = '0; mvalid[i] = 0; end
    mptr = 0;
    test_reset();
    test_direct_fill();
    test_backpressure();
    test_ack_only();
    test_round_robin();
    test_reset_mid();
    test_mode_switch();
    idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
